host_bus_bridge: RTL and testbench



---
 rtl/host_bus_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_host_bus_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_bridge.sv
// Host-bus bridge: turns asynchronous host read/write strobes into single
// edge-triggered VRAM accesses or bank-register accesses, and sequences the
// 74VLC245 transceiver direction so the FPGA and the transceiver never drive
// the data lines at the same time.
module host_bus_bridge #(
    parameter int ADDR_W      = 11,
    parameter int BANK_W      = 2,
    parameter int DATA_W      = 8,
    parameter int RD_LAT      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [ADDR_W-1:0]        hostBusAddr,
    input  logic [DATA_W-1:0]        hostBusDataIn,
    output logic [DATA_W-1:0]        hostBusDataOut,
    output logic                     hostBusDataOE,
    input  logic                     nHostRMEM,
    input  logic                     nHostWMEM,
    input  logic                     nHostVRAMEn,
    input  logic                     nHostBankRegEn,
    output logic                     hostBusDir,
    output logic [BANK_W+ADDR_W-1:0] vramAddr,
    output logic [DATA_W-1:0]        vramWrData,
    output logic                     vramWr,
    output logic                     vramRd,
    input  logic [DATA_W-1:0]        vramRdData,
    output logic [BANK_W-1:0]        bankReg
);

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_WAIT,
        RD_DRIVE,
        WAIT_REL
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] rd_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] ven_sync;
    logic [SYNC_STAGES-1:0] ben_sync;
    logic                   rd_prev;
    logic                   wr_prev;

    logic rd_s;
    logic wr_s;
    logic ven_s;
    logic ben_s;
    logic rd_fall;
    logic wr_fall;
    logic sel_ok;

    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic [BANK_W-1:0] bank_q, bank_next;
    logic [DATA_W-1:0] rdata_q, rdata_next;
    logic              oe_q, oe_next;
    logic              dir_q, dir_next;
    logic [CNT_W-1:0]  cnt_q, cnt_next;
    logic              bank_target_q, bank_target_next;
    logic              turn_q, turn_next;

    // Synchronise the four asynchronous strobes/enables and remember the
    // previous synchronised strobe levels for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_sync  <= '1;
            wr_sync  <= '1;
            ven_sync <= '1;
            ben_sync <= '1;
            rd_prev  <= 1'b1;
            wr_prev  <= 1'b1;
        end else begin
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0],  nHostRMEM};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0],  nHostWMEM};
            ven_sync <= {ven_sync[SYNC_STAGES-2:0], nHostVRAMEn};
            ben_sync <= {ben_sync[SYNC_STAGES-2:0], nHostBankRegEn};
            rd_prev  <= rd_s;
            wr_prev  <= wr_s;
        end
    end

    assign rd_s    = rd_sync[SYNC_STAGES-1];
    assign wr_s    = wr_sync[SYNC_STAGES-1];
    assign ven_s   = ven_sync[SYNC_STAGES-1];
    assign ben_s   = ben_sync[SYNC_STAGES-1];
    assign rd_fall = rd_prev && !rd_s;
    assign wr_fall = wr_prev && !wr_s;

    // A start is valid only with exactly one target selected and only one
    // strobe low; anything else is a host protocol error.
    assign sel_ok = (ven_s ^ ben_s) && (rd_s || wr_s);

    // State and datapath registers; reset aborts whatever access is running.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state         <= IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            bank_q        <= '0;
            rdata_q       <= '0;
            oe_q          <= 1'b0;
            dir_q         <= 1'b1;
            cnt_q         <= '0;
            bank_target_q <= 1'b0;
            turn_q        <= 1'b0;
        end else begin
            state         <= state_next;
            addr_q        <= addr_next;
            data_q        <= data_next;
            bank_q        <= bank_next;
            rdata_q       <= rdata_next;
            oe_q          <= oe_next;
            dir_q         <= dir_next;
            cnt_q         <= cnt_next;
            bank_target_q <= bank_target_next;
            turn_q        <= turn_next;
        end
    end

    // Next-state and next-register logic for the access sequencer.
    always_comb begin
        state_next       = state;
        addr_next        = addr_q;
        data_next        = data_q;
        bank_next        = bank_q;
        rdata_next       = rdata_q;
        oe_next          = oe_q;
        dir_next         = dir_q;
        cnt_next         = cnt_q;
        bank_target_next = bank_target_q;
        turn_next        = turn_q;

        case (state)
            IDLE: begin
                if (rd_fall || wr_fall) begin
                    if (!sel_ok) begin
                        state_next = WAIT_REL;
                    end else begin
                        addr_next = hostBusAddr;
                        data_next = hostBusDataIn;
                        if (!wr_s) begin
                            if (!ven_s) begin
                                state_next = WR;
                            end else begin
                                bank_next  = hostBusDataIn[BANK_W-1:0];
                                state_next = WAIT_REL;
                            end
                        end else begin
                            dir_next         = 1'b0;
                            cnt_next         = CNT_INIT;
                            bank_target_next = !ben_s;
                            state_next       = RD_WAIT;
                        end
                    end
                end
            end

            WR: begin
                state_next = WAIT_REL;
            end

            RD_WAIT: begin
                if (rd_s) begin
                    oe_next    = 1'b0;
                    turn_next  = 1'b1;
                    state_next = WAIT_REL;
                end else begin
                    cnt_next = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        rdata_next = bank_target_q ? DATA_W'(bank_q) : vramRdData;
                        oe_next    = 1'b1;
                        state_next = RD_DRIVE;
                    end
                end
            end

            RD_DRIVE: begin
                if (rd_s) begin
                    oe_next    = 1'b0;
                    turn_next  = 1'b1;
                    state_next = WAIT_REL;
                end
            end

            WAIT_REL: begin
                if (turn_q) begin
                    dir_next  = 1'b1;
                    turn_next = 1'b0;
                end
                if (rd_s && wr_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign vramWr         = (state == WR);
    assign vramRd         = (state == RD_WAIT) && !bank_target_q && (cnt_q == CNT_INIT);
    assign vramAddr       = {bank_q, addr_q};
    assign vramWrData     = data_q;
    assign bankReg        = bank_q;
    assign hostBusDataOut = rdata_q;
    assign hostBusDataOE  = oe_q;
    assign hostBusDir     = dir_q;

endmodule

// File: tb/tb_host_bus_bridge.sv
// Directed bench for host_bus_bridge with a write/read scoreboard and a
// small VRAM read model.
module tb_host_bus_bridge;

    localparam int ADDR_W      = 11;
    localparam int BANK_W      = 2;
    localparam int DATA_W      = 8;
    localparam int RD_LAT      = 2;
    localparam int SYNC_STAGES = 2;

    logic                     clk = 1'b0;
    logic                     nrst;
    logic [ADDR_W-1:0]        hostBusAddr;
    logic [DATA_W-1:0]        hostBusDataIn;
    logic [DATA_W-1:0]        hostBusDataOut;
    logic                     hostBusDataOE;
    logic                     nHostRMEM;
    logic                     nHostWMEM;
    logic                     nHostVRAMEn;
    logic                     nHostBankRegEn;
    logic                     hostBusDir;
    logic [BANK_W+ADDR_W-1:0] vramAddr;
    logic [DATA_W-1:0]        vramWrData;
    logic                     vramWr;
    logic                     vramRd;
    logic [DATA_W-1:0]        vramRdData = '0;
    logic [BANK_W-1:0]        bankReg;

    int checks    = 0;
    int errors    = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int oe_rises  = 0;

    logic [DATA_W-1:0] model_val = 8'h5A;
    logic              oe_prev   = 1'b0;
    logic [20:0]       exp_w;
    logic [7:0]        exp_r;

    logic [20:0] wr_q[$];
    logic [7:0]  rd_q[$];

    host_bus_bridge #(
        .ADDR_W      (ADDR_W),
        .BANK_W      (BANK_W),
        .DATA_W      (DATA_W),
        .RD_LAT      (RD_LAT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .hostBusAddr    (hostBusAddr),
        .hostBusDataIn  (hostBusDataIn),
        .hostBusDataOut (hostBusDataOut),
        .hostBusDataOE  (hostBusDataOE),
        .nHostRMEM      (nHostRMEM),
        .nHostWMEM      (nHostWMEM),
        .nHostVRAMEn    (nHostVRAMEn),
        .nHostBankRegEn (nHostBankRegEn),
        .hostBusDir     (hostBusDir),
        .vramAddr       (vramAddr),
        .vramWrData     (vramWrData),
        .vramWr         (vramWr),
        .vramRd         (vramRd),
        .vramRdData     (vramRdData),
        .bankReg        (bankReg)
    );

    always #5 clk = ~clk;

    // VRAM model: data is present for exactly the cycle the bridge should
    // capture it (RD_LAT = 2), and zero otherwise.
    always @(posedge clk) begin
        vramRdData <= (vramRd === 1'b1) ? model_val : 8'h00;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One complete host access: strobe low for 'hold' cycles, then release
    // and let the bridge settle back to IDLE.
    task automatic applyStimulus(input logic is_wr, input logic ven, input logic ben,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input int hold);
        hostBusAddr    = addr;
        hostBusDataIn  = data;
        nHostVRAMEn    = ven;
        nHostBankRegEn = ben;
        if (is_wr) nHostWMEM = 1'b0;
        else       nHostRMEM = 1'b0;
        tick(hold);
        nHostWMEM = 1'b1;
        nHostRMEM = 1'b1;
        tick(4);
        nHostVRAMEn    = 1'b1;
        nHostBankRegEn = 1'b1;
        tick(2);
    endtask

    // Scoreboard monitor: pops expected writes on vramWr and expected read
    // data on each rising edge of hostBusDataOE.
    always @(negedge clk) begin
        if (vramWr === 1'b1) begin
            wr_pulses++;
            checkOutput("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                exp_w = wr_q.pop_front();
                checkOutput("wr_addr", 32'(vramAddr), 32'(exp_w[20:8]));
                checkOutput("wr_data", 32'(vramWrData), 32'(exp_w[7:0]));
            end
        end
        if (vramRd === 1'b1) rd_pulses++;
        if (hostBusDataOE === 1'b1 && oe_prev !== 1'b1) begin
            oe_rises++;
            checkOutput("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                exp_r = rd_q.pop_front();
                checkOutput("rd_data", 32'(hostBusDataOut), 32'(exp_r));
            end
        end
        oe_prev = hostBusDataOE;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wr_before;
        int rd_before;
        int oe_before;

        // Reset with random inputs
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hostBusAddr    = ADDR_W'($urandom);
            hostBusDataIn  = DATA_W'($urandom);
            nHostRMEM      = 1'($urandom);
            nHostWMEM      = 1'($urandom);
            nHostVRAMEn    = 1'($urandom);
            nHostBankRegEn = 1'($urandom);
            tick(1);
        end
        checkOutput("rst_oe",    32'(hostBusDataOE),  32'd0);
        checkOutput("rst_dir",   32'(hostBusDir),     32'd1);
        checkOutput("rst_bank",  32'(bankReg),        32'd0);
        checkOutput("rst_dout",  32'(hostBusDataOut), 32'd0);
        checkOutput("rst_addr",  32'(vramAddr),       32'd0);
        checkOutput("rst_wdata", 32'(vramWrData),     32'd0);
        checkOutput("rst_wr",    32'(vramWr),         32'd0);
        checkOutput("rst_rd",    32'(vramRd),         32'd0);

        nHostRMEM      = 1'b1;
        nHostWMEM      = 1'b1;
        nHostVRAMEn    = 1'b1;
        nHostBankRegEn = 1'b1;
        nrst           = 1'b1;
        tick(20);
        checkOutput("idle_wr_pulses", 32'(wr_pulses), 32'd0);
        checkOutput("idle_rd_pulses", 32'(rd_pulses), 32'd0);

        // Bank write 0x03, then VRAM write 0xA5 @ 0x123 held 10 cycles
        applyStimulus(1'b1, 1'b1, 1'b0, 11'h000, 8'h03, 6);
        checkOutput("bank_after_wr3", 32'(bankReg), 32'd3);
        wr_before = wr_pulses;
        wr_q.push_back({13'h1923, 8'hA5});
        applyStimulus(1'b1, 1'b0, 1'b1, 11'h123, 8'hA5, 10);
        checkOutput("vram_wr_single_pulse", 32'(wr_pulses - wr_before), 32'd1);

        // Directed VRAM read timing (SYNC_STAGES = 2, RD_LAT = 2)
        rd_before = rd_pulses;
        model_val = 8'h5A;
        rd_q.push_back(8'h5A);
        hostBusAddr = 11'h055;
        nHostVRAMEn = 1'b0;
        nHostRMEM   = 1'b0;
        tick(1);
        checkOutput("rd_T0_vramRd", 32'(vramRd),     32'd0);
        checkOutput("rd_T0_dir",    32'(hostBusDir), 32'd1);
        tick(1);
        checkOutput("rd_T1_vramRd", 32'(vramRd),     32'd0);
        checkOutput("rd_T1_dir",    32'(hostBusDir), 32'd1);
        tick(1);
        checkOutput("rd_T2_vramRd", 32'(vramRd),        32'd1);
        checkOutput("rd_T2_dir",    32'(hostBusDir),    32'd0);
        checkOutput("rd_T2_oe",     32'(hostBusDataOE), 32'd0);
        tick(1);
        checkOutput("rd_T3_vramRd", 32'(vramRd),        32'd0);
        checkOutput("rd_T3_oe",     32'(hostBusDataOE), 32'd0);
        tick(1);
        checkOutput("rd_T4_oe",     32'(hostBusDataOE),  32'd1);
        checkOutput("rd_T4_data",   32'(hostBusDataOut), 32'h5A);
        tick(3);
        checkOutput("rd_hold_oe",   32'(hostBusDataOE),  32'd1);
        nHostRMEM = 1'b1;
        tick(2);
        checkOutput("rel_R1_oe",  32'(hostBusDataOE), 32'd1);
        tick(1);
        checkOutput("rel_R2_oe",  32'(hostBusDataOE), 32'd0);
        checkOutput("rel_R2_dir", 32'(hostBusDir),    32'd0);
        tick(1);
        checkOutput("rel_R3_dir", 32'(hostBusDir),    32'd1);
        nHostVRAMEn = 1'b1;
        tick(3);
        checkOutput("vram_rd_single_pulse", 32'(rd_pulses - rd_before), 32'd1);

        // Bank = 2 via 0xFE (only low bits kept), then bank read
        applyStimulus(1'b1, 1'b1, 1'b0, 11'h000, 8'hFE, 6);
        checkOutput("bank_after_wrFE", 32'(bankReg), 32'd2);
        rd_before = rd_pulses;
        oe_before = oe_rises;
        rd_q.push_back(8'h02);
        applyStimulus(1'b0, 1'b1, 1'b0, 11'h000, 8'h00, 8);
        checkOutput("bank_rd_no_vramRd", 32'(rd_pulses - rd_before), 32'd0);
        checkOutput("bank_rd_oe_once",   32'(oe_rises - oe_before),  32'd1);

        // Protocol errors: both enables low (write), neither low (read),
        // both strobes low
        wr_before = wr_pulses;
        applyStimulus(1'b1, 1'b0, 1'b0, 11'h0AA, 8'h01, 6);
        checkOutput("perr_both_en_wr", 32'(wr_pulses - wr_before), 32'd0);
        checkOutput("perr_both_en_bank", 32'(bankReg), 32'd2);
        rd_before = rd_pulses;
        oe_before = oe_rises;
        applyStimulus(1'b0, 1'b1, 1'b1, 11'h0AA, 8'h00, 8);
        checkOutput("perr_no_en_rd",  32'(rd_pulses - rd_before), 32'd0);
        checkOutput("perr_no_en_oe",  32'(oe_rises - oe_before),  32'd0);
        checkOutput("perr_no_en_dir", 32'(hostBusDir), 32'd1);
        nHostRMEM = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 11'h0AA, 8'h77, 6);
        checkOutput("perr_both_strb_wr", 32'(wr_pulses - wr_before), 32'd0);
        checkOutput("perr_both_strb_oe", 32'(oe_rises - oe_before),  32'd0);
        wr_q.push_back({13'h17FF, 8'h3C});
        applyStimulus(1'b1, 1'b0, 1'b1, 11'h7FF, 8'h3C, 6);
        checkOutput("post_perr_wr", 32'(wr_pulses - wr_before), 32'd1);

        // Abort: strobe released one cycle into RD_WAIT
        oe_before = oe_rises;
        hostBusAddr = 11'h010;
        nHostVRAMEn = 1'b0;
        nHostRMEM   = 1'b0;
        tick(1);
        nHostRMEM = 1'b1;
        tick(2);
        checkOutput("abort_T2_vramRd", 32'(vramRd),     32'd1);
        checkOutput("abort_T2_dir",    32'(hostBusDir), 32'd0);
        tick(1);
        checkOutput("abort_T3_oe",  32'(hostBusDataOE), 32'd0);
        checkOutput("abort_T3_dir", 32'(hostBusDir),    32'd0);
        tick(1);
        checkOutput("abort_T4_dir", 32'(hostBusDir),    32'd1);
        nHostVRAMEn = 1'b1;
        tick(4);
        checkOutput("abort_no_oe", 32'(oe_rises - oe_before), 32'd0);

        // Reset asserted during RD_DRIVE
        rd_q.push_back(8'h5A);
        hostBusAddr = 11'h020;
        nHostVRAMEn = 1'b0;
        nHostRMEM   = 1'b0;
        tick(6);
        checkOutput("rstdrv_oe_before", 32'(hostBusDataOE), 32'd1);
        nrst = 1'b0;
        tick(1);
        checkOutput("rstdrv_oe",  32'(hostBusDataOE), 32'd0);
        checkOutput("rstdrv_dir", 32'(hostBusDir),    32'd1);
        nHostRMEM   = 1'b1;
        nHostVRAMEn = 1'b1;
        tick(2);
        nrst = 1'b1;
        tick(6);
        checkOutput("rstdrv_idle_oe", 32'(hostBusDataOE), 32'd0);

        checkOutput("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        checkOutput("rd_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
